// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe_if
//  Purpose  : Command/result bus of the pipelined ALU. The command side
//             carries opcode and operands with a valid/ready handshake, the
//             result side carries result, flags and error with its own
//             valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_pipe_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    // command side
    logic               i_valid;
    logic               o_ready;
    logic [NB_OP-1:0]   i_opcode;
    logic [NB_DATA-1:0] i_ope1;
    logic [NB_DATA-1:0] i_ope2;
    // result side
    logic               o_valid;
    logic               i_ready;
    logic [NB_DATA-1:0] o_result;
    logic [3:0]         o_flags;
    logic               o_err;

    // ALU side of the bus
    modport slave (
        input  i_valid, i_opcode, i_ope1, i_ope2, i_ready,
        output o_ready, o_valid, o_result, o_flags, o_err
    );

    // command source / result sink side of the bus
    modport master (
        output i_valid, i_opcode, i_ope1, i_ope2, i_ready,
        input  o_ready, o_valid, o_result, o_flags, o_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Two-stage pipelined ALU. Stage 1 registers the accepted
//             command, stage 2 registers result, {Z,N,C,V} flags and the
//             illegal-opcode error. A single advance enable moves both stages
//             whenever the output register is empty or being drained.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  wire logic   i_clk,
    input  wire logic   i_rst_n,
    alu_pipe_if.slave   bus
);

    localparam logic [NB_OP-1:0] c_op_add = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] c_op_sub = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] c_op_and = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] c_op_or  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] c_op_xor = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] c_op_sra = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] c_op_srl = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] c_op_nor = NB_OP'(6'b100111);

    // shift amounts at or above the width saturate
    localparam logic [NB_DATA-1:0] c_nb_data = NB_DATA'(NB_DATA);

    // stage 1: captured command
    logic               s1_valid_q, s1_valid_d;
    logic [NB_OP-1:0]   s1_op_q,    s1_op_d;
    logic [NB_DATA-1:0] s1_a_q,     s1_a_d;
    logic [NB_DATA-1:0] s1_b_q,     s1_b_d;

    // stage 2: registered result beat
    logic               o_valid_q,  o_valid_d;
    logic [NB_DATA-1:0] result_q,   result_d;
    logic [3:0]         flags_q,    flags_d;
    logic               err_q,      err_d;

    // combinational ALU outputs
    logic [NB_DATA-1:0] w_res;
    logic [NB_DATA:0]   w_sum;
    logic               w_c;
    logic               w_v;
    logic               w_err;
    logic [3:0]         w_flags;

    logic               w_en;

    // whole pipe moves when the output slot is free or being taken
    assign w_en = !o_valid_q || bus.i_ready;

    // stage 1 next state: load on accept, empty when nothing offered
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (w_en) begin
            s1_valid_d = bus.i_valid;
            if (bus.i_valid) begin
                s1_op_d = bus.i_opcode;
                s1_a_d  = bus.i_ope1;
                s1_b_d  = bus.i_ope2;
            end
        end
    end

    // ALU datapath on the stage-1 registers
    always_comb begin
        w_res = '0;
        w_sum = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (s1_op_q)
            c_op_add: begin
                w_sum = {1'b0, s1_a_q} + {1'b0, s1_b_q};
                w_res = w_sum[NB_DATA-1:0];
                w_c   = w_sum[NB_DATA];
                w_v   = (s1_a_q[NB_DATA-1] == s1_b_q[NB_DATA-1]) &&
                        (w_res[NB_DATA-1] != s1_a_q[NB_DATA-1]);
            end
            c_op_sub: begin
                // the extra bit of the widened difference is the borrow
                w_sum = {1'b0, s1_a_q} - {1'b0, s1_b_q};
                w_res = w_sum[NB_DATA-1:0];
                w_c   = w_sum[NB_DATA];
                w_v   = (s1_a_q[NB_DATA-1] != s1_b_q[NB_DATA-1]) &&
                        (w_res[NB_DATA-1] != s1_a_q[NB_DATA-1]);
            end
            c_op_and: w_res = s1_a_q & s1_b_q;
            c_op_or:  w_res = s1_a_q | s1_b_q;
            c_op_xor: w_res = s1_a_q ^ s1_b_q;
            c_op_nor: w_res = ~(s1_a_q | s1_b_q);
            c_op_srl: begin
                if (s1_b_q >= c_nb_data) w_res = '0;
                else                     w_res = s1_a_q >> s1_b_q;
            end
            c_op_sra: begin
                if (s1_b_q >= c_nb_data) w_res = {NB_DATA{s1_a_q[NB_DATA-1]}};
                else                     w_res = NB_DATA'($signed(s1_a_q) >>> s1_b_q);
            end
            default: w_err = 1'b1;
        endcase
        // illegal beats report result 0 with all flags clear
        if (w_err) w_flags = 4'b0000;
        else       w_flags = {(w_res == '0), w_res[NB_DATA-1], w_c, w_v};
    end

    // stage 2 next state: payload only refreshed by a real command
    always_comb begin
        o_valid_d = o_valid_q;
        result_d  = result_q;
        flags_d   = flags_q;
        err_d     = err_q;
        if (w_en) begin
            o_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = w_res;
                flags_d  = w_flags;
                err_d    = w_err;
            end
        end
    end

    // pipeline registers, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            o_valid_q  <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            o_valid_q  <= o_valid_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            err_q      <= err_d;
        end
    end

    assign bus.o_ready  = w_en;
    assign bus.o_valid  = o_valid_q;
    assign bus.o_result = result_q;
    assign bus.o_flags  = flags_q;
    assign bus.o_err    = err_q;

endmodule
`default_nettype wire
